// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage
// (fixed priority) and a DMA/debug port that is guaranteed a slot after STARVE_LIMIT waits.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_WORDS   = 64
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        err_oob
);
    localparam int unsigned       WCNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(STARVE_LIMIT);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [31:0]       dma_rdata_q, dma_rdata_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    logic              err_oob_q, err_oob_d;

    logic cpu_in_range;
    logic dma_in_range;
    logic force_dma;
    logic cpu_gnt;
    logic dma_gnt_w;
    logic oob_access;

    // Handshake: dma_req is a valid that holds dma_we/dma_addr/dma_wdata stable until
    // dma_gnt (the ready) is seen at a posedge; the access happens in that same cycle.
    always_comb begin
        cpu_in_range = ({2'b00, cpu_addr[31:2]} < ADDR_WORDS);
        dma_in_range = ({2'b00, dma_addr[31:2]} < ADDR_WORDS);
        force_dma    = cpu_req && dma_req && (wcnt_q == WCNT_MAX);
        // clrn gates the grants directly so an interrupted grant never reaches the negedge write.
        cpu_gnt      = clrn && cpu_req && !force_dma;
        dma_gnt_w    = clrn && dma_req && (!cpu_req || force_dma);
        cpu_stall    = clrn && cpu_req && !cpu_gnt;
        dma_gnt      = dma_gnt_w;
        cpu_rdata    = mem_rdata;

        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_we     = 1'b0;
        oob_access = 1'b0;
        if (dma_gnt_w) begin
            mem_addr   = dma_in_range ? dma_addr : 32'h0;
            mem_wdata  = dma_wdata;
            mem_we     = dma_we && dma_in_range;
            oob_access = !dma_in_range;
        end else if (cpu_gnt) begin
            mem_addr   = cpu_in_range ? cpu_addr : 32'h0;
            mem_wdata  = cpu_wdata;
            mem_we     = cpu_we && cpu_in_range;
            oob_access = !cpu_in_range;
        end
    end

    always_comb begin
        wcnt_d = '0;
        if (dma_req && !dma_gnt_w) begin
            wcnt_d = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
        end

        dma_rvalid_d = dma_gnt_w && !dma_we;
        dma_rdata_d  = dma_rdata_q;
        if (dma_rvalid_d) begin
            dma_rdata_d = dma_in_range ? mem_rdata : 32'h0;
        end

        err_oob_d = err_oob_q || oob_access;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wcnt_q       <= '0;
            dma_rdata_q  <= 32'h0;
            dma_rvalid_q <= 1'b0;
            err_oob_q    <= 1'b0;
        end else begin
            wcnt_q       <= wcnt_d;
            dma_rdata_q  <= dma_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
            err_oob_q    <= err_oob_d;
        end
    end

    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;
    assign err_oob    = err_oob_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Bench for dmem_arbiter: directed scenarios for reset, grants, starvation, abandonment
// and out-of-range handling, then a randomized run against a transaction-level model.
module tb_dmem_arbiter;
    localparam int LIMIT = 4;
    localparam int AW    = 64;

    logic        clk;
    logic        clrn;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic        err_oob;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem     [AW];
    logic [31:0] exp_mem [AW];

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_WORDS(AW)) dut (
        .clk(clk), .clrn(clrn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .err_oob(err_oob)
    );

    // Clock and reset-free memory model: writes on negedge, combinational read.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 2) return 32'h2000_0022;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    initial begin
        for (int i = 0; i < AW; i++) mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (mem_we && (mem_addr / 4) < AW) mem[mem_addr[7:2]] = mem_wdata;
        end
    end

    assign mem_rdata = ((mem_addr / 4) < AW) ? mem[mem_addr[7:2]] : 32'h0BAD_0BAD;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Driver tasks; every test starts and ends 1ns after a posedge.
    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1111_1111;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h14; dma_wdata = 32'h2222_2222;
        for (int c = 0; c < 2; c++) begin
            #3;
            n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_dma_gnt c%0d: got %b exp 0", c, dma_gnt); end
            n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_stall c%0d: got %b exp 0", c, cpu_stall); end
            n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we c%0d: got %b exp 0", c, mem_we); end
            n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_dma_rvalid c%0d: got %b exp 0", c, dma_rvalid); end
            n_checks++; if (dma_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_dma_rdata c%0d: got %h exp 0", c, dma_rdata); end
            n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL rst_err_oob c%0d: got %b exp 0", c, err_oob); end
            cycle();
        end
        n_checks++; if (mem[4] !== exp_mem[4]) begin n_fail++; $display("FAIL rst_mem4: got %h exp %h", mem[4], exp_mem[4]); end
        n_checks++; if (mem[5] !== exp_mem[5]) begin n_fail++; $display("FAIL rst_mem5: got %h exp %h", mem[5], exp_mem[5]); end
        idle();
        clrn = 1'b1;
        cycle();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h08;
        #3;
        n_checks++; if (cpu_rdata !== 32'h2000_0022) begin n_fail++; $display("FAIL cpu_read_data: got %h exp 20000022", cpu_rdata); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_read_stall: got %b exp 0", cpu_stall); end
        n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL cpu_read_dma_gnt: got %b exp 0", dma_gnt); end
        n_checks++; if (mem_addr !== 32'h08) begin n_fail++; $display("FAIL cpu_read_addr: got %h exp 8", mem_addr); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL cpu_read_we: got %b exp 0", mem_we); end
        cycle();
        idle();
        cycle();
    endtask

    task automatic test_dma_rw();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0C; dma_wdata = 32'hDEAD_BEEF;
        #3;
        n_checks++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dma_wr_gnt: got %b exp 1", dma_gnt); end
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL dma_wr_we: got %b exp 1", mem_we); end
        n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dma_wr_wdata: got %h exp deadbeef", mem_wdata); end
        exp_mem[3] = 32'hDEAD_BEEF;
        cycle();
        dma_we = 1'b0; dma_wdata = 32'h0;
        #3;
        n_checks++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dma_rd_gnt: got %b exp 1", dma_gnt); end
        n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dma_wr_no_rvalid: got %b exp 0", dma_rvalid); end
        n_checks++; if (mem[3] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dma_wr_mem: got %h exp deadbeef", mem[3]); end
        cycle();
        idle();
        #3;
        n_checks++; if (dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL dma_rd_rvalid: got %b exp 1", dma_rvalid); end
        n_checks++; if (dma_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dma_rd_data: got %h exp deadbeef", dma_rdata); end
        cycle();
        #3;
        n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dma_rd_pulse: got %b exp 0", dma_rvalid); end
        cycle();
    endtask

    task automatic test_starvation();
        logic exp_d;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h04;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h14;
        for (int c = 1; c <= 2 * (LIMIT + 1); c++) begin
            exp_d = ((c % (LIMIT + 1)) == 0);
            #3;
            n_checks++; if (dma_gnt !== exp_d) begin n_fail++; $display("FAIL starve_gnt c%0d: got %b exp %b", c, dma_gnt, exp_d); end
            n_checks++; if (cpu_stall !== exp_d) begin n_fail++; $display("FAIL starve_stall c%0d: got %b exp %b", c, cpu_stall, exp_d); end
            n_checks++; if (mem_addr !== (exp_d ? 32'h14 : 32'h04)) begin n_fail++; $display("FAIL starve_addr c%0d: got %h exp_dma %b", c, mem_addr, exp_d); end
            cycle();
        end
        idle();
        cycle();
    endtask

    task automatic test_abandon();
        logic exp_d;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h04;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h10; dma_wdata = 32'h5555_AAAA;
        for (int c = 0; c < 2; c++) begin
            #3;
            n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL abandon_blocked_gnt c%0d: got %b exp 0", c, dma_gnt); end
            n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL abandon_blocked_we c%0d: got %b exp 0", c, mem_we); end
            cycle();
        end
        dma_req = 1'b0;
        #3;
        n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL abandon_drop_gnt: got %b exp 0", dma_gnt); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL abandon_drop_we: got %b exp 0", mem_we); end
        cycle();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h18; dma_wdata = 32'h0;
        for (int c = 0; c <= LIMIT; c++) begin
            exp_d = (c == LIMIT);
            #3;
            n_checks++; if (dma_gnt !== exp_d) begin n_fail++; $display("FAIL abandon_rewait_gnt c%0d: got %b exp %b", c, dma_gnt, exp_d); end
            cycle();
        end
        idle();
        cycle();
        n_checks++; if (mem[4] !== exp_mem[4]) begin n_fail++; $display("FAIL abandon_mem: got %h exp %h", mem[4], exp_mem[4]); end
    endtask

    task automatic test_oob();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h1234_5678;
        #3;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL oob_we: got %b exp 0", mem_we); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL oob_addr: got %h exp 0", mem_addr); end
        n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL oob_err_early: got %b exp 0", err_oob); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL oob_stall: got %b exp 0", cpu_stall); end
        cycle();
        idle();
        for (int c = 0; c < 3; c++) begin
            #3;
            n_checks++; if (err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_err_sticky c%0d: got %b exp 1", c, err_oob); end
            cycle();
        end
        n_checks++; if (mem[0] !== exp_mem[0]) begin n_fail++; $display("FAIL oob_mem0: got %h exp %h", mem[0], exp_mem[0]); end
        #3;
        clrn = 1'b0;
        #1;
        n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL oob_err_reset: got %b exp 0", err_oob); end
        cycle();
        clrn = 1'b1;
        cycle();
    endtask

    task automatic test_reset_mid_grant();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200;
        #3;
        n_checks++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL oob_rd_gnt: got %b exp 1", dma_gnt); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL oob_rd_addr: got %h exp 0", mem_addr); end
        cycle();
        dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'hCAFE_F00D;
        #1;
        n_checks++; if (dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL oob_rd_rvalid: got %b exp 1", dma_rvalid); end
        n_checks++; if (dma_rdata !== 32'h0) begin n_fail++; $display("FAIL oob_rd_data: got %h exp 0", dma_rdata); end
        n_checks++; if (err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_rd_err: got %b exp 1", err_oob); end
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_we: got %b exp 1", mem_we); end
        clrn = 1'b0;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %b exp 0", mem_we); end
        n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt: got %b exp 0", dma_gnt); end
        n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid: got %b exp 0", dma_rvalid); end
        n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b exp 0", err_oob); end
        cycle();
        n_checks++; if (mem[8] !== exp_mem[8]) begin n_fail++; $display("FAIL midrst_mem: got %h exp %h", mem[8], exp_mem[8]); end
        idle();
        clrn = 1'b1;
        cycle();
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return (32'($urandom_range(AW, 4000)) << 2) | 32'($urandom_range(0, 3));
        if (r == 1) return $urandom | 32'h8000_0000;
        return (32'($urandom_range(0, AW - 1)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    task automatic test_random(input int n);
        logic [31:0] exp_q[$];
        int          blocked;
        logic        exp_err, exp_rv, exp_dma, exp_cpu, granted, in_rng;
        logic        dma_active, g_we, exp_we;
        logic [31:0] g_addr, g_wd, exp_addr, exp_wd, exp_rd;
        blocked = 0; exp_err = 1'b0; exp_rv = 1'b0; dma_active = 1'b0;
        clrn = 1'b0;
        idle();
        cycle();
        clrn = 1'b1;
        for (int c = 0; c < n; c++) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = rand_addr();
            cpu_wdata = $urandom;
            if (dma_active && $urandom_range(0, 7) == 0) begin
                dma_active = 1'b0;
            end else if (!dma_active && $urandom_range(0, 1) == 1) begin
                dma_active = 1'b1;
                dma_we     = 1'($urandom_range(0, 1));
                dma_addr   = rand_addr();
                dma_wdata  = $urandom;
            end
            dma_req = dma_active;

            exp_dma = dma_active && (!cpu_req || blocked == LIMIT);
            exp_cpu = cpu_req && !exp_dma;
            granted = exp_dma || exp_cpu;
            g_addr  = exp_dma ? dma_addr : cpu_addr;
            g_wd    = exp_dma ? dma_wdata : cpu_wdata;
            g_we    = exp_dma ? dma_we : cpu_we;
            in_rng  = (g_addr / 4) < AW;
            exp_addr = !granted ? cpu_addr : (in_rng ? g_addr : 32'h0);
            exp_wd   = g_wd;
            exp_we   = granted && g_we && in_rng;

            #3;
            n_checks++; if (dma_gnt !== exp_dma) begin n_fail++; $display("FAIL rnd_dma_gnt c%0d: got %b exp %b", c, dma_gnt, exp_dma); end
            n_checks++; if (cpu_stall !== (cpu_req && exp_dma)) begin n_fail++; $display("FAIL rnd_cpu_stall c%0d: got %b exp %b", c, cpu_stall, cpu_req && exp_dma); end
            n_checks++; if (mem_we !== exp_we) begin n_fail++; $display("FAIL rnd_mem_we c%0d: got %b exp %b", c, mem_we, exp_we); end
            n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_mem_addr c%0d: got %h exp %h", c, mem_addr, exp_addr); end
            n_checks++; if (mem_wdata !== exp_wd) begin n_fail++; $display("FAIL rnd_mem_wdata c%0d: got %h exp %h", c, mem_wdata, exp_wd); end
            n_checks++; if (dma_rvalid !== exp_rv) begin n_fail++; $display("FAIL rnd_dma_rvalid c%0d: got %b exp %b", c, dma_rvalid, exp_rv); end
            if (exp_rv) begin
                exp_rd = exp_q.pop_front();
                n_checks++; if (dma_rdata !== exp_rd) begin n_fail++; $display("FAIL rnd_dma_rdata c%0d: got %h exp %h", c, dma_rdata, exp_rd); end
            end
            n_checks++; if (err_oob !== exp_err) begin n_fail++; $display("FAIL rnd_err_oob c%0d: got %b exp %b", c, err_oob, exp_err); end
            if (exp_cpu && !cpu_we && in_rng) begin
                n_checks++; if (cpu_rdata !== exp_mem[cpu_addr[7:2]]) begin n_fail++; $display("FAIL rnd_cpu_rdata c%0d: got %h exp %h", c, cpu_rdata, exp_mem[cpu_addr[7:2]]); end
            end

            exp_rv = exp_dma && !dma_we;
            if (exp_rv) exp_q.push_back(in_rng ? exp_mem[dma_addr[7:2]] : 32'h0);
            if (exp_we) exp_mem[g_addr[7:2]] = g_wd;
            if (granted && !in_rng) exp_err = 1'b1;
            blocked = (dma_active && !exp_dma) ? ((blocked < LIMIT) ? blocked + 1 : LIMIT) : 0;
            if (exp_dma) dma_active = 1'b0;
            cycle();
        end
        idle();
        cycle();
        for (int i = 0; i < AW; i++) begin
            n_checks++; if (mem[i] !== exp_mem[i]) begin n_fail++; $display("FAIL rnd_mem_final[%0d]: got %h exp %h", i, mem[i], exp_mem[i]); end
        end
    endtask

    initial begin
        clrn = 1'b0;
        idle();
        for (int i = 0; i < AW; i++) exp_mem[i] = init_word(i);
        cycle();
        test_reset();
        test_cpu_read();
        test_dma_rw();
        test_starvation();
        test_abandon();
        test_oob();
        test_reset_mid_grant();
        test_random(800);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter placed in front of the single-port data memory. It shares the memory between the pipeline MEM stage (CPU port) and a DMA/debug port. The CPU gets fixed priority, and a starvation counter guarantees the DMA port a slot. The block also decodes out-of-range addresses and suppresses writes to them. It sits between the EX/MEM pipeline register outputs and the data memory, and its stall output feeds the pipeline hazard/stall logic.

## Interface

Parameters:
- STARVE_LIMIT, 4: consecutive blocked DMA cycles before DMA is forced ahead of the CPU (legal 1..15).
- ADDR_WORDS, 64: number of implemented 32-bit words; byte addresses at or above 4*ADDR_WORDS are out of range.

Ports:
- clk  in  1  system clock; all state updates on posedge
- clrn  in  1  asynchronous, active-low reset
- cpu_req  in  1  MEM stage requests a memory access this cycle
- cpu_we  in  1  CPU access is a write
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  load data to MEM stage, combinational
- cpu_stall  out  1  CPU request not serviced this cycle; pipeline must hold
- dma_req  in  1  DMA requests an access; held until granted
- dma_we  in  1  DMA access is a write
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_gnt  out  1  DMA access performed this cycle
- dma_rdata  out  32  registered DMA read data
- dma_rvalid  out  1  dma_rdata valid; one-cycle pulse
- mem_addr  out  32  byte address to data memory
- mem_wdata  out  32  write data to data memory
- mem_we  out  1  write enable to data memory (memory writes on negedge clk)
- mem_rdata  in  32  combinational read data from data memory
- err_oob  out  1  sticky flag: a granted access was out of range

## Operation

Grant decision is combinational from the current requests and the registered wait counter `wcnt`, which is wide enough for STARVE_LIMIT:
- No request: no grant, mem_we=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
- cpu_req only: CPU granted.
- dma_req only: DMA granted (dma_gnt=1).
- Both requests and wcnt<STARVE_LIMIT: CPU granted and DMA blocked.
- Both requests and wcnt==STARVE_LIMIT: DMA granted and cpu_stall=1.

Datapath muxing:
- The granted side drives mem_addr and mem_wdata.
- mem_we = granted side's we AND address in range.
- cpu_rdata = mem_rdata at all times; it is meaningful only when the CPU is granted and the access is a read.

Wait counter:
- Increments when dma_req=1 and dma_gnt=0, saturating at STARVE_LIMIT.
- Clears to 0 on any cycle with dma_gnt=1 or dma_req=0.

DMA handshake:
- The master holds dma_req, dma_we, dma_addr and dma_wdata stable until it samples dma_gnt=1 at a posedge.
- Deasserting dma_req before the grant abandons the request; no access occurs and wcnt clears.

DMA read return:
- On a granted DMA read, mem_rdata is registered into dma_rdata at that posedge.
- dma_rvalid is 1 for the following cycle only.
- Out-of-range DMA reads return 0 in dma_rdata, with dma_rvalid still pulsed.

Out-of-range handling:
- Applies to any granted access with addr[31:2] >= ADDR_WORDS.
- mem_we is forced to 0, mem_addr is driven to 0, and err_oob sets at the next posedge.
- err_oob stays set until reset.

Address bits [1:0] are passed through unchanged; no alignment check is performed.

## Timing

Reset values, asserted asynchronously while clrn=0:
- wcnt=0, dma_rdata=0, dma_rvalid=0, err_oob=0.
- dma_gnt=0, cpu_stall=0, mem_we=0; all requests are ignored.

Latency:
- CPU read: data is available in the same cycle (combinational path through the memory).
- CPU write: memory is written at the negedge of the grant cycle.
- DMA write: completes at the negedge of the dma_gnt cycle.
- DMA read: dma_rvalid is asserted one cycle after dma_gnt.

Throughput and stalls:
- One access per clk.
- Under continuous contention the pattern is STARVE_LIMIT CPU grants, then 1 DMA grant, repeating.
- cpu_stall is high for exactly that one forced-DMA cycle.

Reset edge cases:
- Reset asserted in a grant cycle: the negedge write is suppressed because mem_we is forced to 0 immediately.
- Reset asserted while dma_rvalid is pending: the read result is lost.
- Deassertion of clrn is assumed synchronised upstream.

## Test plan

- Reset, then CPU read at 0x08 with the memory preloaded with 0x20000022 at word 2: cpu_rdata=0x20000022 in the same cycle, cpu_stall=0, dma_gnt=0.
- DMA-only write of 0xDEADBEEF to 0x0C, then DMA read of 0x0C: dma_gnt=1 in each request cycle; dma_rvalid=1 one cycle after the read grant with dma_rdata=0xDEADBEEF.
- cpu_req and dma_req both held high (STARVE_LIMIT=4):
  - CPU granted in cycles 1-4.
  - In cycle 5, dma_gnt=1 and cpu_stall=1.
  - wcnt returns to 0 and the pattern repeats.
- DMA request dropped after 2 blocked cycles: no dma_gnt, no write reaches memory, and a new request waits a full 4 cycles again.
- CPU write to 0x100 with ADDR_WORDS=64: mem_we=0, memory unchanged, err_oob=1 from the next cycle and held until clrn=0.
- clrn pulsed low mid-DMA-write grant: mem_we=0 and dma_gnt=0 immediately; all registered outputs are 0 while in reset.
